// File: rtl/call_request_register.sv
// call_request_register: latches hall calls and offers the nearest one as target (CALL_CANCEL_EN: repeat pulse cancels a non-target call)
module call_request_register #(
    parameter int FLOOR_W  = 2,
    parameter int NF_CHECK = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [2**FLOOR_W-1:0]   call_pulse,
    input  logic [FLOOR_W-1:0]      cur_floor,
    input  logic                    at_floor,
    input  logic                    ack,
    output logic [2**FLOOR_W-1:0]   pending,
    output logic                    req_valid,
    output logic [FLOOR_W-1:0]      req_floor,
    output logic                    serve_done
);
    localparam int NF = 2**FLOOR_W;
    localparam logic [FLOOR_W:0] NF_V = (FLOOR_W+1)'(NF);

    typedef enum logic [1:0] {IDLE, OFFER, SERVING} state_t;

    state_t              r_state, w_next;
    logic [NF-1:0]       r_pending, w_pending_nx, w_set, w_clr;
    logic [FLOOR_W-1:0]  r_target, w_cur, w_best_f, w_best_d;
    logic [FLOOR_W-1:0]  w_dist [NF];
    logic                w_found, w_serve, r_serve_done;

    assign w_cur   = (NF_CHECK != 0 && {1'b0, cur_floor} >= NF_V) ? '0 : cur_floor;
    assign w_serve = r_state == SERVING && at_floor && w_cur == r_target;
    assign w_set   = call_pulse & ~({NF{at_floor}} & (NF'(1) << w_cur));
    assign w_clr   = {NF{w_serve}} & (NF'(1) << r_target);

`ifdef CALL_CANCEL_EN
    logic [NF-1:0] w_tgt_mask;
    assign w_tgt_mask   = {NF{r_state != IDLE}} & (NF'(1) << r_target);
    assign w_pending_nx = (r_pending | w_set) & ~(w_set & r_pending & ~w_tgt_mask) & ~w_clr;
`else
    assign w_pending_nx = (r_pending | w_set) & ~w_clr;
`endif

    for (genvar g = 0; g < NF; g++) begin : g_dist
        assign w_dist[g] = (FLOOR_W'(g) > w_cur) ? FLOOR_W'(g) - w_cur : w_cur - FLOOR_W'(g);
    end

    // ascending scan with <= lets the higher floor win a distance tie
    always_comb begin
        w_found  = 1'b0;
        w_best_f = '0;
        w_best_d = '0;
        for (int i = 0; i < NF; i++) begin
            if (r_pending[i] && (!w_found || w_dist[i] <= w_best_d)) begin
                w_found  = 1'b1;
                w_best_f = FLOOR_W'(i);
                w_best_d = w_dist[i];
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (|r_pending) w_next = OFFER;
            OFFER:   if (ack) w_next = SERVING;
            SERVING: if (w_serve) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_pending    <= '0;
            r_target     <= '0;
            r_serve_done <= 1'b0;
        end else begin
            r_state      <= w_next;
            r_pending    <= w_pending_nx;
            r_serve_done <= w_serve;
            if (r_state == IDLE && |r_pending) r_target <= w_best_f;
        end
    end

    assign pending    = r_pending;
    assign req_valid  = r_state == OFFER;
    assign req_floor  = r_target;
    assign serve_done = r_serve_done;
endmodule

// File: tb/tb_call_request_register.sv
// tb_call_request_register: directed vectors with hand-computed expectations for call_request_register
module tb_call_request_register;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] call_pulse = '0;
    logic [1:0] cur_floor = '0;
    logic       at_floor = 1'b0;
    logic       ack = 1'b0;
    logic [3:0] pending;
    logic       req_valid;
    logic [1:0] req_floor;
    logic       serve_done;
    int         n_vec = 0;
    int         n_err = 0;

    call_request_register dut (
        .clk(clk), .rst(rst), .call_pulse(call_pulse), .cur_floor(cur_floor),
        .at_floor(at_floor), .ack(ack), .pending(pending), .req_valid(req_valid),
        .req_floor(req_floor), .serve_done(serve_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        tick();
        tick();
        rst = 1'b0;
        check("rst_pending", 32'(pending), 0);
        check("rst_valid", 32'(req_valid), 0);
        check("rst_floor", 32'(req_floor), 0);
        check("rst_done", 32'(serve_done), 0);

        call_pulse = 4'b0100;
        tick();
        call_pulse = '0;
        check("single_pend", 32'(pending), 4'b0100);
        check("single_nolat", 32'(req_valid), 0);
        tick();
        check("single_valid", 32'(req_valid), 1);
        check("single_floor", 32'(req_floor), 2);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("serving_valid", 32'(req_valid), 0);
        check("serving_floor", 32'(req_floor), 2);
        cur_floor = 2'd2;
        at_floor = 1'b1;
        call_pulse = 4'b0001;
        tick();
        call_pulse = '0;
        at_floor = 1'b0;
        check("serve_done", 32'(serve_done), 1);
        check("serve_pend", 32'(pending), 4'b0001);
        check("serve_idle", 32'(req_valid), 0);
        tick();
        check("b2b_valid", 32'(req_valid), 1);
        check("b2b_floor", 32'(req_floor), 0);
        check("done_pulse", 32'(serve_done), 0);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        cur_floor = 2'd1;
        call_pulse = 4'b1001;
        tick();
        call_pulse = '0;
        tick();
        check("nearest", 32'(req_floor), 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cur_floor = 2'd2;
        call_pulse = 4'b1010;
        tick();
        call_pulse = '0;
        tick();
        check("tie_high", 32'(req_floor), 3);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("hold_valid", 32'(req_valid), 1);
            check("hold_floor", 32'(req_floor), 3);
        end
        call_pulse = 4'b0100;
        tick();
        call_pulse = '0;
        check("nopreempt_floor", 32'(req_floor), 3);
        check("nopreempt_pend", 32'(pending), 4'b1110);

        ack = 1'b1;
        tick();
        ack = 1'b0;
        check("serving2_valid", 32'(req_valid), 0);
        call_pulse = 4'b0010;
        tick();
        call_pulse = '0;
`ifdef CALL_CANCEL_EN
        check("cancel_other", 32'(pending), 4'b1100);
`else
        check("cancel_other", 32'(pending), 4'b1110);
`endif
        call_pulse = 4'b1000;
        tick();
        call_pulse = '0;
`ifdef CALL_CANCEL_EN
        check("cancel_target", 32'(pending), 4'b1100);
`else
        check("cancel_target", 32'(pending), 4'b1110);
`endif
        check("target_kept", 32'(req_floor), 3);

        rst = 1'b1;
        cur_floor = 2'd3;
        at_floor = 1'b1;
        tick();
        rst = 1'b0;
        at_floor = 1'b0;
        check("rstsrv_done", 32'(serve_done), 0);
        tick();
        check("rstsrv_done2", 32'(serve_done), 0);
        check("rstsrv_pend", 32'(pending), 0);
        check("rstsrv_valid", 32'(req_valid), 0);

        cur_floor = 2'd0;
        at_floor = 1'b1;
        call_pulse = 4'b0001;
        tick();
        call_pulse = '0;
        at_floor = 1'b0;
        check("discard_pend", 32'(pending), 0);
        tick();
        check("discard_valid", 32'(req_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
